ex_muldiv: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline; it sits beside the ALU and directly upstream of the EX/MEM pipeline register. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO registers. MFHI/MFLO results feed the ALU result mux that drives `ALUResE` into EX/MEM. While an operation is in flight it asserts `busy`, and the hazard unit stalls any HI/LO-class instruction in ID.

---
 rtl/ex_muldiv_pkg.sv | 26 ++
 rtl/muldiv_div_iter.sv | 54 +++++
 rtl/ex_muldiv.sv | 131 +++++++++++++
 tb/tb_ex_muldiv.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: word type, MDU op
// encodings, FSM state encodings and a small magnitude helper.
package ex_muldiv_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] Word;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    // Two's-complement magnitude; 0x8000_0000 maps to itself, which the
    // divider then treats as the unsigned value 2^31.
    function automatic Word absVal(input Word v, input logic signedOp);
        return (signedOp && v[WORD_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// 32-step restoring divider on unsigned magnitudes: one quotient bit per
// cycle, MSB first. Sign handling is left to the caller.
module muldiv_div_iter
    import ex_muldiv_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic step,
    input  Word  dividend,
    input  Word  divisor,
    output Word  quotient,
    output Word  remainder,
    output logic lastStep
);

    Word              rem;
    Word              quo;
    logic [5:0]       count;
    logic [WORD_W:0]  partial;
    logic             fits;
    Word              diff;

    // quo doubles as the dividend shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    always_comb begin
        partial = {rem, quo[WORD_W-1]};
        fits    = partial >= {1'b0, divisor};
        diff    = partial[WORD_W-1:0] - divisor;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem   <= '0;
            quo   <= '0;
            count <= '0;
        end else if (load) begin
            rem   <= '0;
            quo   <= dividend;
            count <= '0;
        end else if (step && count != 6'd32) begin
            rem   <= fits ? diff : partial[WORD_W-1:0];
            quo   <= {quo[WORD_W-2:0], fits};
            count <= count + 6'd1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign lastStep  = (count == 6'd31);

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit holding architectural HI/LO.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are ignored.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int MUL_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [1:0]  state;
    logic [7:0]  mulCnt;
    logic [63:0] product;
    logic [63:0] extA;
    logic [63:0] extB;
    logic [63:0] prodNext;
    logic        signedMul;

    // Sign- or zero-extending to 64 bits makes the low 64 bits of one
    // unsigned multiply correct for both MULT and MULTU.
    always_comb begin
        signedMul = (op == MDU_MULT);
        extA      = {{32{signedMul & srcA[31]}}, srcA};
        extB      = {{32{signedMul & srcB[31]}}, srcB};
        prodNext  = extA * extB;
    end

`ifdef MULDIV_DIV_EN
    logic issueDiv;
    logic signedDiv;
    Word  magA;
    Word  magB;
    Word  divQ;
    Word  divR;
    logic divLast;
    logic negQ;
    logic negR;
    logic divZero;

    always_comb begin
        issueDiv  = start && (state == S_IDLE) && (op == MDU_DIV || op == MDU_DIVU);
        signedDiv = (op == MDU_DIV);
        magA      = absVal(srcA, signedDiv);
        magB      = absVal(srcB, signedDiv);
    end

    muldiv_div_iter u_divIter (
        .clk       (clk),
        .reset     (reset),
        .load      (issueDiv),
        .step      (state == S_DIV),
        .dividend  (magA),
        .divisor   (magB),
        .quotient  (divQ),
        .remainder (divR),
        .lastStep  (divLast)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            mulCnt  <= '0;
            product <= '0;
            HI      <= '0;
            LO      <= '0;
`ifdef MULDIV_DIV_EN
            negQ    <= 1'b0;
            negR    <= 1'b0;
            divZero <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT, MDU_MULTU: begin
                                product <= prodNext;
                                mulCnt  <= 8'(MUL_LAT - 1);
                                state   <= S_MUL;
                            end
                            MDU_MTHI: HI <= srcA;
                            MDU_MTLO: LO <= srcA;
`ifdef MULDIV_DIV_EN
                            MDU_DIV, MDU_DIVU: begin
                                negQ    <= signedDiv && (srcA[31] ^ srcB[31]);
                                negR    <= signedDiv && srcA[31];
                                divZero <= (srcB == '0);
                                state   <= S_DIV;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (mulCnt == '0) begin
                        {HI, LO} <= product;
                        state    <= S_IDLE;
                    end else begin
                        mulCnt <= mulCnt - 8'd1;
                    end
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    if (divLast) state <= S_FIX;
                end
                S_FIX: begin
                    // Divide-by-zero leaves remainder = |srcA|, so the normal
                    // remainder sign fix already restores HI = srcA.
                    HI    <= negR ? -divR : divR;
                    LO    <= divZero ? '1 : (negQ ? -divQ : divQ);
                    state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table, hand sequences for reset,
// MTHI/MTLO, ignored start and back-to-back issue, then random ops vs a model.
module tb_ex_muldiv;

    localparam int MUL_LAT = 5;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int nVec = 0;
    int nErr = 0;
    logic [31:0] curHi = '0;
    logic [31:0] curLo = '0;

    ex_muldiv #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expLat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Architectural result from plain integer arithmetic.
    function automatic void refOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hiIn, input logic [31:0] loIn,
                                  output logic [31:0] hiOut, output logic [31:0] loOut,
                                  output int lat);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        hiOut = hiIn;
        loOut = loIn;
        lat   = 0;
        case (o)
            3'd0: begin p = 64'(sa * sb); {hiOut, loOut} = p; lat = MUL_LAT; end
            3'd1: begin p = ua * ub;      {hiOut, loOut} = p; lat = MUL_LAT; end
            3'd2, 3'd3: begin
                if (DIV_EN) begin
                    lat = 33;
                    if (b == 32'd0) begin
                        hiOut = a;
                        loOut = 32'hFFFF_FFFF;
                    end else if (o == 3'd2) begin
                        q = sa / sb;
                        r = sa % sb;
                        loOut = q[31:0];
                        hiOut = r[31:0];
                    end else begin
                        p = ua / ub;
                        loOut = p[31:0];
                        p = ua % ub;
                        hiOut = p[31:0];
                    end
                end
            end
            3'd4: hiOut = a;
            3'd5: loOut = a;
            default: ;
        endcase
    endfunction

    // Called at a negedge; returns at the first negedge with busy low.
    task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int busyCycles);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start = 1'b0;
        busyCycles = 0;
        while (busy && busyCycles < 100) begin
            busyCycles++;
            @(negedge clk);
        end
    endtask

    task automatic applyCheck(input string name, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] expHi,
                              input logic [31:0] expLo, input int expLat);
        int cyc;
        runOp(o, a, b, cyc);
        check({name, " HI"}, 64'(HI), 64'(expHi));
        check({name, " LO"}, 64'(LO), 64'(expLo));
        check({name, " busy cycles"}, 64'(cyc), 64'(expLat));
        curHi = expHi;
        curLo = expLo;
    endtask

    task automatic modelCheck(input string name, input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b);
        logic [31:0] h;
        logic [31:0] l;
        int          lat;
        refOp(o, a, b, curHi, curLo, h, l, lat);
        applyCheck(name, o, a, b, h, l, lat);
    endtask

    vec_t vecs[8];

    initial begin
        int          cyc;
        int          total;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          elat;

        vecs[0] = '{"mult_neg",   3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
        vecs[1] = '{"multu_big",  3'd1, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, MUL_LAT};
        vecs[2] = '{"div_m7_2",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3] = '{"divu_100_7", 3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        33};
        vecs[4] = '{"divu_zero",  3'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 33};
        vecs[5] = '{"div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
        vecs[6] = '{"nop6",       3'd6, 32'h1111_1111, 32'h2222_2222, 32'd0,         32'd0,         0};
        vecs[7] = '{"div_zero_s", 3'd2, 32'hFFFF_FF00, 32'd0,         32'hFFFF_FF00, 32'hFFFF_FFFF, 33};

        reset = 1'b0;
        start = 1'b0;
        op    = 3'd7;
        srcA  = '0;
        srcB  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset HI", 64'(HI), 64'(0));
        check("reset LO", 64'(LO), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        // Table: DIV rows hold HI/LO when the divider is not built; no-ops always hold.
        for (int i = 0; i < 8; i++) begin
            eh   = vecs[i].expHi;
            el   = vecs[i].expLo;
            elat = vecs[i].expLat;
            if ((!DIV_EN && (vecs[i].op == 3'd2 || vecs[i].op == 3'd3)) || vecs[i].op >= 3'd6) begin
                eh   = curHi;
                el   = curLo;
                elat = 0;
            end
            applyCheck(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, eh, el, elat);
        end

        // MTHI then MTLO on consecutive edges.
        start = 1'b1; op = 3'd4; srcA = 32'hA5A5_A5A5; srcB = '0;
        @(negedge clk);
        check("mthi HI", 64'(HI), 64'hA5A5_A5A5);
        check("mthi busy", 64'(busy), 64'(0));
        op = 3'd5; srcA = 32'h5A5A_5A5A;
        @(negedge clk);
        start = 1'b0;
        check("mtlo LO", 64'(LO), 64'h5A5A_5A5A);
        check("mtlo HI kept", 64'(HI), 64'hA5A5_A5A5);
        check("mtlo busy", 64'(busy), 64'(0));
        curHi = 32'hA5A5_A5A5;
        curLo = 32'h5A5A_5A5A;

        // start pulses while busy must be ignored.
        start = 1'b1; op = 3'd0; srcA = 32'd1000; srcB = 32'hFFFF_FFF6;
        @(negedge clk);
        start = 1'b1; op = 3'd4; srcA = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b1; op = 3'd1; srcA = 32'd5; srcB = 32'd5;
        @(negedge clk);
        start = 1'b0;
        cyc = 3;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("ignored start busy cycles", 64'(cyc), 64'(MUL_LAT + 1));
        check("ignored start HI", 64'(HI), 64'hFFFF_FFFF);
        check("ignored start LO", 64'(LO), 64'(32'hFFFF_D8F0));
        curHi = 32'hFFFF_FFFF;
        curLo = 32'hFFFF_D8F0;

        // Back-to-back: second op issued in the cycle busy falls.
        runOp(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        total = cyc;
        check("b2b first LO", 64'(LO), 64'(1));
        check("b2b first HI", 64'(HI), 64'(0));
        runOp(3'd1, 32'h8000_0000, 32'd4, cyc);
        total += cyc;
        check("b2b second HI", 64'(HI), 64'(2));
        check("b2b second LO", 64'(LO), 64'(0));
        check("b2b total busy", 64'(total), 64'(2 * MUL_LAT));
        curHi = 32'd2;
        curLo = 32'd0;

        // Asynchronous reset mid-operation.
        start = 1'b1; op = DIV_EN ? 3'd2 : 3'd0; srcA = 32'h0001_0000; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (DIV_EN ? 9 : 2) @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'(0));
        check("abort HI", 64'(HI), 64'(0));
        check("abort LO", 64'(LO), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        curHi = '0;
        curLo = '0;
        applyCheck("post-reset mult", 3'd0, 32'd7, 32'd6, 32'd0, 32'd42, MUL_LAT);

        // Randomized ops against the reference model, with corner operands mixed in.
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            modelCheck($sformatf("rand%0d op%0d", i, o), o, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
